// File: rtl/adc_dac_control.sv
`timescale 1ns/1ps
// adc_dac_control: serial DAC writer (16-bit frame + LDAC load strobe)
// and free-running serial ADC reader (16-clock frame, 10-bit result).
// Ports:
//   clk_50MHz, reset_n        system clock, async active-low reset
//   pulse_value_DAC[11:0]     DAC code, taken on push_val_to_DAC
//   pulse_out[11:0]           code most recently loaded into the DAC
//   SCK_DAC, CS_DAC, SDI_DAC  DAC serial bus (clock, CS_n, data)
//   LDAC_DAC                  DAC load strobe, active low
//   reset_DAC, reset_ADC      device resets, active low
//   Sclk_ADC, CS_ADC, Din_ADC ADC serial bus (clock, CS_n, config)
//   Dout_ADC                  ADC serial data in
//   output_ADC[9:0]           last completed conversion
//   ch_display_select         ADC channel (0 = CH0, 1 = CH1)
module adc_dac_control #(
  parameter int SCK_HALF = 25,
  parameter int ADC_GAP  = 50
) (
  input  logic        clk_50MHz,
  input  logic        reset_n,
  input  logic [11:0] pulse_value_DAC,
  input  logic        push_val_to_DAC,
  output logic [11:0] pulse_out,
  output logic        SCK_DAC,
  output logic        CS_DAC,
  output logic        SDI_DAC,
  output logic        LDAC_DAC,
  output logic        reset_DAC,
  output logic        reset_ADC,
  output logic        Sclk_ADC,
  output logic        CS_ADC,
  output logic        Din_ADC,
  input  logic        Dout_ADC,
  output logic [9:0]  output_ADC,
  input  logic        ch_display_select
);

  localparam int PER  = 2 * SCK_HALF;
  localparam int DCW  = $clog2(PER);
  localparam int AMAX = (ADC_GAP > PER) ? ADC_GAP : PER;
  localparam int ACW  = $clog2(AMAX);

  localparam logic [DCW-1:0] D_HALF  = DCW'(SCK_HALF);
  localparam logic [DCW-1:0] D_HLAST = DCW'(SCK_HALF - 1);
  localparam logic [DCW-1:0] D_LAST  = DCW'(PER - 1);

  localparam logic [ACW-1:0] A_HALF  = ACW'(SCK_HALF);
  localparam logic [ACW-1:0] A_HLAST = ACW'(SCK_HALF - 1);
  localparam logic [ACW-1:0] A_LAST  = ACW'(PER - 1);
  localparam logic [ACW-1:0] A_GLAST = ACW'(ADC_GAP - 1);

  // DAC frame prefix: channel A, unbuffered, 1x gain, active
  localparam logic [3:0] DAC_CMD = 4'b0011;

  typedef enum logic [1:0] {
    D_IDLE,
    D_SHIFT,
    D_GAP,
    D_LOAD
  } dac_st_e;

  typedef enum logic {
    A_WAIT,
    A_FRAME
  } adc_st_e;

  // ---------------- device resets ----------------
  logic dev_rst_q;

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) dev_rst_q <= 1'b0;
    else          dev_rst_q <= 1'b1;
  end

  assign reset_DAC = dev_rst_q;
  assign reset_ADC = dev_rst_q;

  // ---------------- DAC engine ----------------
  dac_st_e        d_st, d_st_n;
  logic [DCW-1:0] d_cnt, d_cnt_n;
  logic [3:0]     d_bit, d_bit_n;
  logic [15:0]    d_sr, d_sr_n;
  logic [11:0]    d_data, d_data_n;
  logic           pend_v, pend_v_n;
  logic [11:0]    pend_d, pend_d_n;
  logic [11:0]    pulse_n;
  logic           d_start;
  logic [11:0]    d_src;

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      d_st      <= D_IDLE;
      d_cnt     <= '0;
      d_bit     <= '0;
      d_sr      <= '0;
      d_data    <= '0;
      pend_v    <= 1'b0;
      pend_d    <= '0;
      pulse_out <= '0;
    end else begin
      d_st      <= d_st_n;
      d_cnt     <= d_cnt_n;
      d_bit     <= d_bit_n;
      d_sr      <= d_sr_n;
      d_data    <= d_data_n;
      pend_v    <= pend_v_n;
      pend_d    <= pend_d_n;
      pulse_out <= pulse_n;
    end
  end

  always_comb begin
    d_st_n   = d_st;
    d_cnt_n  = d_cnt;
    d_bit_n  = d_bit;
    d_sr_n   = d_sr;
    d_data_n = d_data;
    pend_v_n = pend_v;
    pend_d_n = pend_d;
    pulse_n  = pulse_out;
    d_start  = 1'b0;
    d_src    = pulse_value_DAC;
    unique case (d_st)
      D_IDLE: begin
        if (push_val_to_DAC) d_start = 1'b1;
      end
      D_SHIFT: begin
        d_cnt_n = d_cnt + 1'b1;
        if (d_cnt == D_LAST) begin
          d_cnt_n = '0;
          if (d_bit == 4'd15) begin
            d_st_n = D_GAP;
          end else begin
            d_bit_n = d_bit + 4'd1;
            d_sr_n  = {d_sr[14:0], 1'b0};
          end
        end
      end
      D_GAP: begin
        d_cnt_n = d_cnt + 1'b1;
        if (d_cnt == D_HLAST) begin
          d_cnt_n = '0;
          d_st_n  = D_LOAD;
        end
      end
      D_LOAD: begin
        d_cnt_n = d_cnt + 1'b1;
        if (d_cnt == D_HLAST) begin
          d_cnt_n = '0;
          d_st_n  = D_IDLE;
          pulse_n = d_data;
          // Back-to-back: next frame starts as LDAC rises.
          // A push in this very cycle is newer than pending.
          if (push_val_to_DAC || pend_v) begin
            d_start = 1'b1;
            if (!push_val_to_DAC) d_src = pend_d;
          end
        end
      end
      default: d_st_n = D_IDLE;
    endcase
    if (push_val_to_DAC && d_st != D_IDLE && !d_start) begin
      pend_v_n = 1'b1;
      pend_d_n = pulse_value_DAC;
    end
    if (d_start) begin
      d_st_n   = D_SHIFT;
      d_cnt_n  = '0;
      d_bit_n  = '0;
      d_sr_n   = {DAC_CMD, d_src};
      d_data_n = d_src;
      pend_v_n = 1'b0;
    end
  end

  assign CS_DAC   = (d_st != D_SHIFT);
  assign SCK_DAC  = (d_st == D_SHIFT) && (d_cnt >= D_HALF);
  assign SDI_DAC  = (d_st == D_SHIFT) && d_sr[15];
  assign LDAC_DAC = (d_st != D_LOAD);

  // ---------------- ADC engine ----------------
  adc_st_e        a_st, a_st_n;
  logic [ACW-1:0] a_cnt, a_cnt_n;
  logic [3:0]     a_bit, a_bit_n;
  logic           ch_q, ch_n;
  logic [9:0]     a_sr, a_sr_n;
  logic           a_done, a_done_n;
  logic [9:0]     adc_n;
  logic           a_data_bit;

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      a_st       <= A_WAIT;
      a_cnt      <= '0;
      a_bit      <= '0;
      ch_q       <= 1'b0;
      a_sr       <= '0;
      a_done     <= 1'b0;
      output_ADC <= '0;
    end else begin
      a_st       <= a_st_n;
      a_cnt      <= a_cnt_n;
      a_bit      <= a_bit_n;
      ch_q       <= ch_n;
      a_sr       <= a_sr_n;
      a_done     <= a_done_n;
      output_ADC <= adc_n;
    end
  end

  // bits 6..15 (index 5..14) carry D9..D0
  assign a_data_bit = (a_bit >= 4'd5) && (a_bit <= 4'd14);

  always_comb begin
    a_st_n   = a_st;
    a_cnt_n  = a_cnt;
    a_bit_n  = a_bit;
    ch_n     = ch_q;
    a_sr_n   = a_sr;
    a_done_n = 1'b0;
    adc_n    = a_done ? a_sr : output_ADC;
    unique case (a_st)
      A_WAIT: begin
        a_cnt_n = a_cnt + 1'b1;
        if (a_cnt == A_GLAST) begin
          a_cnt_n = '0;
          a_bit_n = '0;
          a_st_n  = A_FRAME;
          ch_n    = ch_display_select;
        end
      end
      A_FRAME: begin
        a_cnt_n = a_cnt + 1'b1;
        // edge ending this cycle raises Sclk_ADC
        if (a_cnt == A_HLAST && a_data_bit) begin
          a_sr_n = {a_sr[8:0], Dout_ADC};
        end
        if (a_cnt == A_LAST) begin
          a_cnt_n = '0;
          if (a_bit == 4'd15) begin
            a_st_n   = A_WAIT;
            a_done_n = 1'b1;
          end else begin
            a_bit_n = a_bit + 4'd1;
          end
        end
      end
      default: a_st_n = A_WAIT;
    endcase
  end

  assign CS_ADC   = (a_st != A_FRAME);
  assign Sclk_ADC = (a_st == A_FRAME) && (a_cnt >= A_HALF);

  // config word: start, single-ended, channel, MSB-first
  always_comb begin
    Din_ADC = 1'b0;
    if (a_st == A_FRAME) begin
      unique case (1'b1)
        (a_bit == 4'd0): Din_ADC = 1'b1;
        (a_bit == 4'd1): Din_ADC = 1'b1;
        (a_bit == 4'd2): Din_ADC = ch_q;
        (a_bit == 4'd3): Din_ADC = 1'b1;
        default:         Din_ADC = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_dac_control.sv
`timescale 1ns/1ps
// tb_adc_dac_control: scoreboard bench for adc_dac_control.
// DAC frames and ADC conversions checked against queued expectations.
module tb_adc_dac_control;

  logic        clk_50MHz = 1'b0;
  logic        reset_n;
  logic [11:0] pulse_value_DAC;
  logic        push_val_to_DAC;
  logic [11:0] pulse_out;
  logic        SCK_DAC, CS_DAC, SDI_DAC, LDAC_DAC;
  logic        reset_DAC, reset_ADC;
  logic        Sclk_ADC, CS_ADC, Din_ADC;
  logic        Dout_ADC;
  logic [9:0]  output_ADC;
  logic        ch_display_select;

  adc_dac_control #(.SCK_HALF(25), .ADC_GAP(50)) dut (
    .clk_50MHz         (clk_50MHz),
    .reset_n           (reset_n),
    .pulse_value_DAC   (pulse_value_DAC),
    .push_val_to_DAC   (push_val_to_DAC),
    .pulse_out         (pulse_out),
    .SCK_DAC           (SCK_DAC),
    .CS_DAC            (CS_DAC),
    .SDI_DAC           (SDI_DAC),
    .LDAC_DAC          (LDAC_DAC),
    .reset_DAC         (reset_DAC),
    .reset_ADC         (reset_ADC),
    .Sclk_ADC          (Sclk_ADC),
    .CS_ADC            (CS_ADC),
    .Din_ADC           (Din_ADC),
    .Dout_ADC          (Dout_ADC),
    .output_ADC        (output_ADC),
    .ch_display_select (ch_display_select)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int cyc = 0;
  always @(posedge clk_50MHz) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // scoreboards and DAC request model
  logic [11:0] dac_q[$];
  logic [9:0]  adc_q[$];
  bit          m_busy = 0;
  bit          m_pend_v = 0;
  logic [11:0] m_pend = '0;
  int          rst_epoch = 0;
  int          adc_frames = 0;
  logic [9:0]  adc_next;

  // ---------------- DAC monitor ----------------
  initial begin : dac_mon
    logic [15:0] w;
    logic [11:0] e;
    int t0, t1;
    bit ok;
    #5;
    forever begin
      if (CS_DAC !== 1'b0) @(negedge CS_DAC);
      w  = '0;
      ok = 1;
      for (int b = 0; b < 16; b++) begin
        @(posedge SCK_DAC or posedge CS_DAC);
        #1;
        if (CS_DAC === 1'b1) begin
          ok = 0;
          break;
        end
        w = {w[14:0], SDI_DAC};
        if (b == 0) t0 = cyc;
        else if (b == 1) check("sck_dac_period", cyc - t0, 50);
      end
      if (ok) begin
        @(posedge CS_DAC);
        #1;
        ok = reset_n;
      end
      if (!ok) begin
        if (dac_q.size() > 0) void'(dac_q.pop_front());
        continue;
      end
      if (dac_q.size() == 0) begin
        check("dac_extra_frame", dac_q.size(), 1);
        continue;
      end
      e = dac_q.pop_front();
      check("dac_cmd", w[15:12], 4'b0011);
      check("dac_data", w[11:0], e);
      t1 = cyc;
      @(negedge LDAC_DAC);
      check("ldac_delay", cyc - t1, 25);
      t1 = cyc;
      @(posedge LDAC_DAC);
      check("ldac_width", cyc - t1, 25);
      #1;
      check("pulse_out", pulse_out, e);
      if (m_pend_v) begin
        dac_q.push_back(m_pend);
        m_pend_v = 0;
      end else begin
        m_busy = 0;
      end
    end
  end

  // ---------------- ADC model + monitor ----------------
  initial begin : adc_mon
    logic [15:0] dw;
    logic [9:0]  cur, exp_out;
    logic [9:0]  last_adc;
    bit ok, have_rise, chx;
    int tf, tr, ep, out_ep;
    Dout_ADC  = 1'b0;
    last_adc  = '0;
    have_rise = 0;
    out_ep    = 0;
    #5;
    forever begin
      if (CS_ADC !== 1'b0) @(negedge CS_ADC);
      #1;
      if (have_rise) check("adc_gap", cyc - tr, 50);
      tf  = cyc;
      ep  = rst_epoch;
      cur = adc_next;
      adc_q.push_back(cur);
      chx = ch_display_select;
      dw  = '0;
      ok  = 1;
      Dout_ADC = 1'b0;
      for (int b = 0; b < 16; b++) begin
        @(posedge Sclk_ADC or posedge CS_ADC);
        #1;
        if (CS_ADC === 1'b1) begin
          ok = 0;
          break;
        end
        dw = {dw[14:0], Din_ADC};
        @(negedge Sclk_ADC or posedge CS_ADC);
        #1;
        if (b < 15) begin
          if (CS_ADC === 1'b1) begin
            ok = 0;
            break;
          end
          if (b + 1 >= 5 && b + 1 <= 14) Dout_ADC = cur[13-b];
          else Dout_ADC = 1'b0;
        end
      end
      Dout_ADC = 1'b0;
      if (ok && (!reset_n || rst_epoch != ep)) ok = 0;
      if (!ok) begin
        void'(adc_q.pop_front());
        have_rise = 0;
        continue;
      end
      check("adc_low", cyc - tf, 800);
      check("adc_din", dw, {1'b1, 1'b1, chx, 1'b1, 12'h000});
      tr = cyc;
      have_rise = 1;
      if (out_ep != rst_epoch) last_adc = '0;
      @(negedge clk_50MHz);
      check("adc_hold", output_ADC, last_adc);
      @(posedge clk_50MHz);
      #1;
      exp_out = adc_q.pop_front();
      check("adc_out", output_ADC, exp_out);
      last_adc = exp_out;
      out_ep   = rst_epoch;
      adc_frames++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic dac_req(input logic [11:0] v);
    @(negedge clk_50MHz);
    push_val_to_DAC = 1'b1;
    pulse_value_DAC = v;
    if (!m_busy) begin
      dac_q.push_back(v);
      m_busy = 1;
    end else begin
      m_pend   = v;
      m_pend_v = 1;
    end
  endtask

  task automatic dac_rel();
    @(negedge clk_50MHz);
    push_val_to_DAC = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic wait_dac_idle(input int limit);
    for (int i = 0; i < limit && m_busy; i++) @(negedge clk_50MHz);
    check("dac_idle_timeout", m_busy, 0);
  endtask

  task automatic wait_adc_frames(input int n);
    int target;
    target = adc_frames + n;
    for (int i = 0; i < n * 900 + 200 && adc_frames < target; i++)
      @(negedge clk_50MHz);
    check("adc_frame_timeout", adc_frames >= target, 1);
  endtask

  task automatic check_reset_outs();
    check("rst_cs_dac", CS_DAC, 1);
    check("rst_cs_adc", CS_ADC, 1);
    check("rst_ldac", LDAC_DAC, 1);
    check("rst_sck_dac", SCK_DAC, 0);
    check("rst_sclk_adc", Sclk_ADC, 0);
    check("rst_sdi", SDI_DAC, 0);
    check("rst_din", Din_ADC, 0);
    check("rst_pulse_out", pulse_out, 0);
    check("rst_output_adc", output_ADC, 0);
    check("rst_reset_dac", reset_DAC, 0);
    check("rst_reset_adc", reset_ADC, 0);
  endtask

  task automatic release_reset();
    @(negedge clk_50MHz);
    reset_n = 1'b1;
    @(posedge clk_50MHz);
    #1;
    check("rel_reset_dac", reset_DAC, 1);
    check("rel_reset_adc", reset_ADC, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    reset_n           = 1'b0;
    push_val_to_DAC   = 1'b0;
    pulse_value_DAC   = '0;
    ch_display_select = 1'b1;
    adc_next          = 10'h2B7;
    wait_cycles(3);
    check_reset_outs();
    release_reset();

    // single push while idle
    dac_req(12'hA5C);
    dac_rel();
    wait_dac_idle(2000);

    // mid-frame pushes: newest pending wins, 123 dropped
    dac_req(12'h3C3);
    dac_rel();
    wait_cycles(250);
    dac_req(12'h123);
    dac_rel();
    wait_cycles(300);
    dac_req(12'h456);
    dac_rel();
    wait_dac_idle(3000);

    // push held three cycles
    dac_req(12'h111);
    dac_req(12'h222);
    dac_req(12'h333);
    dac_rel();
    wait_dac_idle(3000);

    // toggle channel mid ADC frame while a DAC frame runs
    for (int i = 0; i < 2000 && CS_ADC !== 1'b0; i++)
      @(negedge clk_50MHz);
    check("adc_cs_low_seen", CS_ADC, 0);
    dac_req(12'hFFF);
    dac_rel();
    wait_cycles(300);
    ch_display_select = 1'b0;
    adc_next = 10'h1C4;
    wait_adc_frames(2);
    wait_dac_idle(2000);
    ch_display_select = 1'b1;
    adc_next = 10'h3FF;
    wait_adc_frames(1);
    adc_next = 10'h000;
    wait_adc_frames(1);

    // reset during DAC bit 8
    dac_req(12'h5A5);
    dac_rel();
    wait_cycles(7 * 50 + 20);
    reset_n = 1'b0;
    rst_epoch++;
    m_busy   = 0;
    m_pend_v = 0;
    #1;
    check_reset_outs();
    adc_next = 10'h0AB;
    wait_cycles(3);
    release_reset();
    dac_req(12'h7E1);
    dac_rel();
    wait_dac_idle(2000);
    wait_adc_frames(2);

    check("dac_q_empty", dac_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #(20 * 60000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_dac_control.md
ADC_DAC_CONTROL -- requirements
Module: adc_dac_control

Interface
REQ-001 Parameter SCK_HALF, 25, clk_50MHz cycles per serial-clock half-period (SCK_DAC and Sclk_ADC run at 1 MHz).
REQ-002 Parameter ADC_GAP, 50, clk_50MHz cycles CS_ADC stays high between ADC frames.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk_50MHz  in  1  system clock, all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 pulse_value_DAC  in  12  DAC code to send.
REQ-007 push_val_to_DAC  in  1  one-cycle request to send pulse_value_DAC.
REQ-008 pulse_out  out  12  code most recently latched into the DAC.
REQ-009 SCK_DAC, CS_DAC, SDI_DAC  out  1 each  DAC serial clock, active-low chip select, and serial data.
REQ-010 LDAC_DAC  out  1  active-low DAC load strobe.
REQ-011 reset_DAC, reset_ADC  out  1 each  active-low device resets.
REQ-012 Sclk_ADC, CS_ADC, Din_ADC  out  1 each  ADC serial clock, active-low chip select, and configuration data.
REQ-013 Dout_ADC  in  1  ADC serial data.
REQ-014 output_ADC  out  10  last completed conversion.
REQ-015 ch_display_select  in  1  ADC channel select (0 = CH0, 1 = CH1).

Function
REQ-016 Serial timing for both ports: clock idles low; each bit has SCK_HALF cycles low then SCK_HALF cycles high.
REQ-017 Data outputs change only while their serial clock is low.
REQ-018 The DAC engine is idle with CS_DAC = 1; a push while idle captures pulse_value_DAC and starts a frame on the next cycle.
REQ-019 A push while the DAC is busy is held in a one-deep pending register, newest push wins, and that frame starts immediately after the current frame completes.
REQ-020 DAC frame: CS_DAC low, 16 bits MSB-first = 0,0,1,1 (channel A, unbuffered, 1x gain, active) followed by data[11:0].
REQ-021 After bit 16 falls, CS_DAC goes high; after SCK_HALF cycles, LDAC_DAC is low for SCK_HALF cycles, then returns high.
REQ-022 pulse_out is updated to the frame's data in the same cycle LDAC_DAC rises; the DAC then returns to idle.
REQ-023 The ADC runs free: CS_ADC high for ADC_GAP cycles, then low for a 16-clock frame, repeating.
REQ-024 ch_display_select is sampled once, when CS_ADC falls.
REQ-025 Din_ADC bits 1-4 = 1 (start), 1 (single-ended), ch, 1 (MSB-first); Din_ADC = 0 for bits 5-16.
REQ-026 Dout_ADC is sampled at the Sclk_ADC rising edge of bits 6-15 into D9..D0; bit 5 (null) and bit 16 are ignored.
REQ-027 output_ADC updates atomically one cycle after CS_ADC rises; it holds its previous value between updates.
REQ-028 The DAC and ADC engines are fully independent; simultaneous activity on both has no interaction.
REQ-029 push_val_to_DAC held high for N cycles is treated as one request per cycle, so the last captured value is sent.

Reset
REQ-030 Reset values: CS_DAC = CS_ADC = LDAC_DAC = 1; SCK_DAC = Sclk_ADC = SDI_DAC = Din_ADC = 0.
REQ-031 Reset values: pulse_out = 0, output_ADC = 0, pending request cleared.
REQ-032 reset_DAC and reset_ADC = 0 while reset_n = 0 and 1 from the first clock after release.
REQ-033 Reset mid-frame aborts immediately to the reset values; the ADC starts with a full ADC_GAP after release.

Verification
REQ-034 Push 12'hA5C while idle -> SDI_DAC stream 0011_1010_0101_1100, one LDAC_DAC low pulse of 25 cycles, pulse_out = 12'hA5C.
REQ-035 Push 12'h123 mid-frame, then 12'h456 before the frame ends -> the current frame completes, one frame of 12'h456 follows, and 12'h123 is never sent.
REQ-036 ADC model returns 10'h2B7, ch_display_select = 1 -> Din_ADC = 1,1,1,1; output_ADC = 10'h2B7 after CS_ADC rises.
REQ-037 ch_display_select toggled mid-frame -> Din_ADC bit 3 changes only in the next frame.
REQ-038 reset_n asserted during DAC bit 8 -> CS_DAC = 1 and pulse_out = 0 at once; a push after release completes normally.
REQ-039 Period check: SCK_DAC period = 50 cycles; ADC frame = 800 cycles low plus 50 cycles high.
